ym3012_dac: RTL

Dual-channel digital DAC stage between the YM2151 core's serial sound output and the `audio_a0`/`audio_a1` pins of `top`. It deserialises the YM3012-format floating-point stream (SO, SH1, SH2), converts each channel to 16-bit signed linear PCM, and drives one first-order sigma-delta modulator per channel at the full `sys_clk` rate. The pins are then low-pass filtered off-chip.

---
 rtl/ymdac_pkg.sv | 40 ++++
 rtl/sd_mod1.sv | 39 +++
 rtl/ym3012_dac.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ymdac_pkg.sv
// Shared constants, word layout and float-to-linear conversion for the YM3012 DAC stage.
package ymdac_pkg;

   localparam int unsigned FRAME_BITS_DEF = 16;
   localparam int unsigned SD_WIDTH_DEF   = 16;

   localparam int unsigned PAD_LSB  = 0;
   localparam int unsigned PAD_MSB  = 2;
   localparam int unsigned MANT_LSB = 3;
   localparam int unsigned MANT_MSB = 12;
   localparam int unsigned EXP_LSB  = 13;
   localparam int unsigned EXP_MSB  = 15;

   localparam int unsigned LFSR_W   = 16;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   // Galois right-shift mask for taps 16,14,13,11
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic [EXP_MSB-EXP_LSB:0]   exp;
      logic [MANT_MSB-MANT_LSB:0] mant;
      logic [PAD_MSB-PAD_LSB:0]   pad;
   } ym_word_t;

   // Mantissa MSB is stored inverted; exponent 0 means silence, otherwise shift by E-1.
   function automatic logic signed [15:0] ym_to_linear(input ym_word_t w);
      logic signed [9:0]  m;
      logic signed [15:0] m_ext;
      logic signed [15:0] res;
      m     = {~w.mant[9], w.mant[8:0]};
      m_ext = {{6{m[9]}}, m};
      if (w.exp == 3'd0) begin
         res = 16'sd0;
      end else begin
         res = m_ext <<< (w.exp - 3'd1);
      end
      return res;
   endfunction

endpackage

// File: rtl/sd_mod1.sv
// Single-channel first-order sigma-delta modulator; bit_out is the accumulator carry.
module sd_mod1
   import ymdac_pkg::*;
#(
   parameter int unsigned SD_WIDTH = SD_WIDTH_DEF
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic [SD_WIDTH-1:0] sample,
   input  logic [3:0]          dither,
   output logic                bit_out
);

   localparam int unsigned AW = SD_WIDTH + 1;

   logic [AW-1:0]       acc;
   logic [AW-1:0]       acc_nxt;
   logic [SD_WIDTH-1:0] u;
   logic [AW-1:0]       dither_x;

   // Offset-binary input plus sign-extended dither folded into the running sum
   always_comb begin
      u        = {~sample[SD_WIDTH-1], sample[SD_WIDTH-2:0]};
      dither_x = {{(AW-4){dither[3]}}, dither};
      acc_nxt  = {1'b0, acc[SD_WIDTH-1:0]} + {1'b0, u} + dither_x;
   end

   // Accumulator register; its top bit is the carry of the latest sum
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         acc <= '0;
      end else begin
         acc <= acc_nxt;
      end
   end

   assign bit_out = acc[AW-1];

endmodule

// File: rtl/ym3012_dac.sv
// YM3012-format serial deserialiser, float-to-PCM conversion and two sigma-delta outputs.
// Optional build macro: YM3012_DAC_DITHER_EN adds a shared 16-bit LFSR dither source.
module ym3012_dac
   import ymdac_pkg::*;
#(
   parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
   parameter int unsigned SD_WIDTH   = SD_WIDTH_DEF
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic                       ym_bit_en,
   input  logic                       so,
   input  logic                       sh1,
   input  logic                       sh2,
   output logic signed [SD_WIDTH-1:0] sample_l,
   output logic signed [SD_WIDTH-1:0] sample_r,
   output logic                       sample_valid,
   output logic                       audio_l,
   output logic                       audio_r
);

   logic [FRAME_BITS-1:0] shreg;
   logic                  sh1_q;
   logic                  sh2_q;
   ym_word_t              word_l;
   ym_word_t              word_r;
   logic                  lat_l_q;
   logic                  lat_r_q;
   logic                  fall_l_c;
   logic                  fall_r_c;
   logic [3:0]            dither_l;
   logic [3:0]            dither_r;

   // SH falling edges are only recognised at strobe instants
   always_comb begin
      fall_l_c = ym_bit_en & sh1_q & ~sh1;
      fall_r_c = ym_bit_en & sh2_q & ~sh2;
   end

   // LSB-first shift register and SH history, advanced on each bit strobe
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         shreg <= '0;
         sh1_q <= 1'b0;
         sh2_q <= 1'b0;
      end else if (ym_bit_en) begin
         shreg <= {so, shreg[FRAME_BITS-1:1]};
         sh1_q <= sh1;
         sh2_q <= sh2;
      end
   end

   // Capture the completed word (pre-shift value) on a falling SH edge
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         word_l  <= '0;
         word_r  <= '0;
         lat_l_q <= 1'b0;
         lat_r_q <= 1'b0;
      end else begin
         lat_l_q <= fall_l_c;
         lat_r_q <= fall_r_c;
         if (fall_l_c) begin
            word_l <= ym_word_t'(shreg);
         end
         if (fall_r_c) begin
            word_r <= ym_word_t'(shreg);
         end
      end
   end

   // Convert latched words one cycle later; a single valid pulse covers both channels
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sample_l     <= '0;
         sample_r     <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= lat_l_q | lat_r_q;
         if (lat_l_q) begin
            sample_l <= ym_to_linear(word_l);
         end
         if (lat_r_q) begin
            sample_r <= ym_to_linear(word_r);
         end
      end
   end

`ifdef YM3012_DAC_DITHER_EN
   logic [LFSR_W-1:0] lfsr;

   // Free-running Galois LFSR shared by both channels
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : LFSR_W'(0));
      end
   end

   assign dither_l = lfsr[3:0];
   assign dither_r = {lfsr[0], lfsr[1], lfsr[2], lfsr[3]};
`else
   assign dither_l = 4'd0;
   assign dither_r = 4'd0;
`endif

   sd_mod1 #(.SD_WIDTH(SD_WIDTH)) u_mod_l (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .sample  (sample_l),
      .dither  (dither_l),
      .bit_out (audio_l)
   );

   sd_mod1 #(.SD_WIDTH(SD_WIDTH)) u_mod_r (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .sample  (sample_r),
      .dither  (dither_r),
      .bit_out (audio_r)
   );

endmodule
